mult_div_unit: RTL and testbench

Iterative HI/LO multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file. It consumes the two register-file read ports (rs, rt) for MULT/MULTU/DIV/DIVU and holds the architectural HI/LO registers for MFHI/MFLO and MTHI/MTLO. It replaces a combinational 64-bit multiplier and divider with a WIDTH-cycle shift-add / restoring-division engine and a busy/done handshake toward control.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mult_div_unit_if.sv | 30 +++
 rtl/mult_div_unit.sv | 131 +++++++++++++
 tb/tb_mult_div_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding seen by
// the main decoder, FSM state type and the default datapath width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef logic [1:0] mdu_op_t;

    localparam mdu_op_t OP_MULT  = 2'd0;
    localparam mdu_op_t OP_MULTU = 2'd1;
    localparam mdu_op_t OP_DIV   = 2'd2;
    localparam mdu_op_t OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mdu_state_e;

    function automatic logic is_div_op(input mdu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input mdu_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-side handshake and HI/LO access bundle for mult_div_unit.
interface mult_div_unit_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) ();

    logic             start;
    mdu_op_t          op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the MIPS HI/LO
// registers. One iteration per cycle, WIDTH iterations, then a sign-fixup cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input logic             clk,
    input logic             rst_n,
    mult_div_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e       state;
    logic [CW-1:0]    count;
    logic             div_q;
    logic             neg_result;
    logic             sign_a;
    logic             div_zero;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic               launch_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // Operand magnitudes at launch, one engine step, and the signed result views.
    always_comb begin
        launch_signed = is_signed_op(bus.op);
        abs_a         = cond_neg(bus.src_a, launch_signed & bus.src_a[WIDTH-1]);
        abs_b         = cond_neg(bus.src_b, launch_signed & bus.src_b[WIDTH-1]);
        mul_sum       = {1'b0, acc} + {1'b0, (mq[0] ? mcand : '0)};
        div_shift     = {acc, mq[WIDTH-1]};
        div_diff      = div_shift - {1'b0, mcand};
        prod_fixed    = cond_neg_wide({acc, mq}, neg_result);
        quot_fixed    = cond_neg(mq, neg_result);
        rem_fixed     = cond_neg(acc, sign_a);
    end

    // mq holds the multiplier (shifting out) or the dividend/quotient (shifting in).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            div_q      <= 1'b0;
            neg_result <= 1'b0;
            sign_a     <= 1'b0;
            div_zero   <= 1'b0;
            acc        <= '0;
            mq         <= '0;
            mcand      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        div_q      <= is_div_op(bus.op);
                        sign_a     <= launch_signed & bus.src_a[WIDTH-1];
                        neg_result <= launch_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                        div_zero   <= (bus.src_b == '0);
                        mq         <= is_div_op(bus.op) ? abs_a : abs_b;
                        mcand      <= is_div_op(bus.op) ? abs_b : abs_a;
                        acc        <= '0;
                        count      <= '0;
                        state      <= RUN;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                RUN: begin
                    if (div_q) begin
                        if (!div_diff[WIDTH]) begin
                            acc <= div_diff[WIDTH-1:0];
                            mq  <= {mq[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= div_shift[WIDTH-1:0];
                            mq  <= {mq[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        mq  <= {mul_sum[0], mq[WIDTH-1:1]};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) state <= FIN;
                end
                FIN: begin
                    if (!div_q) begin
                        hi_q <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fixed[WIDTH-1:0];
                    end else if (!div_zero) begin
                        hi_q <= rem_fixed;
                        lo_q <= quot_fixed;
                    end
                    count  <= '0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of MULT/DIV results plus
// hand sequences for MTHI/MTLO, divide-by-zero, ignored restart and mid-run reset.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;
    localparam int LATENCY = W + 1;
    localparam int NVEC = 12;

    typedef struct {
        mdu_op_t      op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [NVEC];

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Launch one operation at a negedge, scramble operands during RUN and wait for done.
    task automatic applyStimulus(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit mt_at_launch, input bit disturb,
                                 output int busy_cycles, output bit got_done);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.hi_we = mt_at_launch;
        bus.lo_we = mt_at_launch;
        bus.wdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        busy_cycles = 0;
        got_done    = 1'b0;
        for (int i = 0; i < 4 * LATENCY; i++) begin
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.busy) busy_cycles++;
            bus.src_a = $urandom;
            bus.src_b = $urandom;
            if (disturb && busy_cycles == 5) begin
                bus.start = 1'b1;
                bus.op    = OP_DIVU;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = 32'h55555555;
            end else begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (!got_done) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int  bc;
        bit  gd;
        int  seen;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[6]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[10] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        vecs[11] = '{OP_DIVU,  32'd5,        32'd9,        32'h00000005, 32'h00000000};

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_hi",   64'(bus.hi),   64'd0);
        checkOutput("reset_lo",   64'(bus.lo),   64'd0);
        rst_n = 1'b1;

        $display("[TB] MTHI/MTLO in IDLE");
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hA5A5A5A5;
        @(negedge clk);
        bus.lo_we = 1'b0;
        bus.wdata = 32'h12345678;
        checkOutput("mt_both_hi", 64'(bus.hi), 64'hA5A5A5A5);
        checkOutput("mt_both_lo", 64'(bus.lo), 64'hA5A5A5A5);
        @(negedge clk);
        bus.hi_we = 1'b0;
        checkOutput("mthi_hi", 64'(bus.hi), 64'h12345678);
        checkOutput("mthi_lo", 64'(bus.lo), 64'hA5A5A5A5);

        $display("[TB] DIVU by zero launched with simultaneous MTHI/MTLO");
        applyStimulus(OP_DIVU, 32'd77, 32'd0, 1'b1, 1'b0, bc, gd);
        checkOutput("divzero_done", 64'(gd), 64'd1);
        checkOutput("divzero_busy", 64'(bc), 64'(LATENCY));
        checkOutput("divzero_hi",   64'(bus.hi), 64'h12345678);
        checkOutput("divzero_lo",   64'(bus.lo), 64'hA5A5A5A5);

        $display("[TB] vector table");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, bc, gd);
            checkOutput($sformatf("vec%0d_hi", i),   64'(bus.hi), 64'(vecs[i].exp_hi));
            checkOutput($sformatf("vec%0d_lo", i),   64'(bus.lo), 64'(vecs[i].exp_lo));
            checkOutput($sformatf("vec%0d_busy", i), 64'(bc),     64'(LATENCY));
            @(negedge clk);
            checkOutput($sformatf("vec%0d_done_width", i), 64'(bus.done), 64'd0);
        end

        $display("[TB] restart and MTHI/MTLO while busy are ignored");
        applyStimulus(OP_MULTU, 32'd7, 32'd6, 1'b0, 1'b1, bc, gd);
        checkOutput("restart_busy", 64'(bc), 64'(LATENCY));
        checkOutput("restart_hi",   64'(bus.hi), 64'd0);
        checkOutput("restart_lo",   64'(bus.lo), 64'd42);
        @(negedge clk);
        checkOutput("restart_no_second_op", 64'(bus.busy), 64'd0);

        $display("[TB] reset in the middle of a DIV");
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("midreset_busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 64'(bus.busy), 64'd0);
        checkOutput("midreset_done", 64'(bus.done), 64'd0);
        checkOutput("midreset_hi",   64'(bus.hi),   64'd0);
        checkOutput("midreset_lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * LATENCY; i++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        checkOutput("midreset_no_done", 64'(seen), 64'd0);
        checkOutput("midreset_hi_after", 64'(bus.hi), 64'd0);
        checkOutput("midreset_lo_after", 64'(bus.lo), 64'd0);

        $display("[TB] operation after reset");
        applyStimulus(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, bc, gd);
        checkOutput("post_reset_hi", 64'(bus.hi), 64'd0);
        checkOutput("post_reset_lo", 64'(bus.lo), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
